systolic_mm_core: RTL and testbench

SYSTOLIC_MM_CORE -- requirements
Module: systolic_mm_core

---
 rtl/systolic_mm_core.sv | 234 +++++++++++++++++++++++
 tb/tb_systolic_mm_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_core.sv
// Output-stationary N x N systolic matrix-multiply core.
// Operands stream in (A then B, row-major), results C stream out row-major.
module systolic_mm_core #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned ACCWIDTH = 2 * BITWIDTH + $clog2(N),
  parameter int unsigned SIGNED   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                acc_clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACCWIDTH-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned IW         = $clog2(N);
  localparam int unsigned CMP_CYCLES = 3 * N - 1;
  localparam int unsigned CW         = $clog2(CMP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CMP_LAST = CW'(CMP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [BITWIDTH-1:0] a_mem  [N][N];
  logic [BITWIDTH-1:0] b_mem  [N][N];
  logic [ACCWIDTH-1:0] acc    [N][N];
  logic [BITWIDTH-1:0] pe_a   [N][N-1];
  logic [BITWIDTH-1:0] pe_b   [N-1][N];
  logic [BITWIDTH-1:0] a_in   [N][N];
  logic [BITWIDTH-1:0] b_in   [N][N];
  logic [BITWIDTH-1:0] feed_a [N];
  logic [BITWIDTH-1:0] feed_b [N];

  logic [IW-1:0] ld_row, ld_col;
  logic [IW-1:0] out_row, out_col;
  logic [IW-1:0] nxt_row, nxt_col;
  logic [CW-1:0] cmp_cnt;

  logic in_xfer, ld_last, cmp_last, out_xfer, out_end, start_ok;
  logic in_ready_d, out_valid_d, busy_d, done_d;

  // Product of two operands, sign- or zero-extended to the accumulator width.
  function automatic logic [ACCWIDTH-1:0] mul_ext(input logic [BITWIDTH-1:0] a,
                                                  input logic [BITWIDTH-1:0] b);
    logic signed [2*BITWIDTH-1:0] sp;
    logic        [2*BITWIDTH-1:0] up;
    sp = $signed({{BITWIDTH{a[BITWIDTH-1]}}, a}) * $signed({{BITWIDTH{b[BITWIDTH-1]}}, b});
    up = {{BITWIDTH{1'b0}}, a} * {{BITWIDTH{1'b0}}, b};
    if (SIGNED != 0) return ACCWIDTH'(sp);
    return ACCWIDTH'(up);
  endfunction

  assign start_ok = (state == S_IDLE) && start;
  assign in_xfer  = in_valid & in_ready;
  assign ld_last  = (ld_row == LAST_IDX) && (ld_col == LAST_IDX);
  assign cmp_last = (cmp_cnt == CMP_LAST);
  assign out_xfer = out_valid & out_ready;
  assign out_end  = out_xfer & out_last;
  assign nxt_col  = (out_col == LAST_IDX) ? '0 : out_col + IW'(1);
  assign nxt_row  = (out_col == LAST_IDX) ? out_row + IW'(1) : out_row;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_LOAD_A;
      S_LOAD_A:  if (in_xfer && ld_last) state_next = S_LOAD_B;
      S_LOAD_B:  if (in_xfer && ld_last) state_next = S_COMPUTE;
      S_COMPUTE: if (cmp_last) state_next = S_DRAIN;
      S_DRAIN:   if (out_end) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from the upcoming state
  always_comb begin
    in_ready_d  = (state_next == S_LOAD_A) || (state_next == S_LOAD_B);
    out_valid_d = (state_next == S_DRAIN);
    busy_d      = (state_next != S_IDLE);
    done_d      = (state == S_DRAIN) && out_end;
  end

  // Control output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Row-major load position, shared by the A and B phases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_row <= '0;
      ld_col <= '0;
    end else if (in_xfer) begin
      if (ld_col == LAST_IDX) begin
        ld_col <= '0;
        ld_row <= (ld_row == LAST_IDX) ? '0 : ld_row + IW'(1);
      end else begin
        ld_col <= ld_col + IW'(1);
      end
    end
  end

  // Compute-phase cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cmp_cnt <= '0;
    else if (state != S_COMPUTE)  cmp_cnt <= '0;
    else if (cmp_last)            cmp_cnt <= '0;
    else                          cmp_cnt <= cmp_cnt + CW'(1);
  end

  // Skewed edge feeds: row/column g sees element k = cmp_cnt - g, zero outside 0..N-1
  for (genvar g = 0; g < N; g++) begin : g_feed
    logic [CW-1:0] tap;
    logic          hit;
    assign tap       = cmp_cnt - CW'(g);
    assign hit       = (cmp_cnt >= CW'(g)) && (tap < CW'(N));
    assign feed_a[g] = hit ? a_mem[g][IW'(tap)] : '0;
    assign feed_b[g] = hit ? b_mem[IW'(tap)][g] : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col

      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = feed_a[gi];
      end else begin : g_a_link
        assign a_in[gi][gj] = pe_a[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = feed_b[gj];
      end else begin : g_b_link
        assign b_in[gi][gj] = pe_b[gi-1][gj];
      end

      // Operand storage for this matrix position
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_mem[gi][gj] <= '0;
          b_mem[gi][gj] <= '0;
        end else if (in_xfer && (ld_row == IW'(gi)) && (ld_col == IW'(gj))) begin
          if (state == S_LOAD_A) a_mem[gi][gj] <= in_data;
          else                   b_mem[gi][gj] <= in_data;
        end
      end

      // Accumulator: cleared on an accepted start with acc_clear, MAC during compute
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     acc[gi][gj] <= '0;
        else if (start_ok && acc_clear) acc[gi][gj] <= '0;
        else if (state == S_COMPUTE)    acc[gi][gj] <= acc[gi][gj] + mul_ext(a_in[gi][gj], b_in[gi][gj]);
      end

      // A operand pipeline to the right neighbour, flushed outside compute
      if (gj < N - 1) begin : g_pa
        always_ff @(posedge clk or negedge reset) begin
          if (!reset)                  pe_a[gi][gj] <= '0;
          else if (state == S_COMPUTE) pe_a[gi][gj] <= a_in[gi][gj];
          else                         pe_a[gi][gj] <= '0;
        end
      end

      // B operand pipeline to the lower neighbour, flushed outside compute
      if (gi < N - 1) begin : g_pb
        always_ff @(posedge clk or negedge reset) begin
          if (!reset)                  pe_b[gi][gj] <= '0;
          else if (state == S_COMPUTE) pe_b[gi][gj] <= b_in[gi][gj];
          else                         pe_b[gi][gj] <= '0;
        end
      end

    end
  end

  // Result stream; the last compute cycle only adds zero padding, so acc is final when sampled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_row  <= '0;
      out_col  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if ((state == S_COMPUTE) && cmp_last) begin
      out_row  <= '0;
      out_col  <= '0;
      out_data <= acc[0][0];
      out_last <= 1'b0;
    end else if ((state == S_DRAIN) && out_xfer) begin
      if (out_last) begin
        out_row  <= '0;
        out_col  <= '0;
        out_data <= '0;
        out_last <= 1'b0;
      end else begin
        out_row  <= nxt_row;
        out_col  <= nxt_col;
        out_data <= acc[nxt_row][nxt_col];
        out_last <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_core.sv
// Randomised bench for systolic_mm_core: four instances (N=4 unsigned,
// N=4 signed, N=2, N=8) checked against a plain matrix-arithmetic model.
module tb_systolic_mm_core;

  logic clk;
  logic rst_n;
  logic st [4];
  logic clr [4];
  logic iv [4];
  logic ordy [4];
  logic [7:0] idata [4];
  logic ir [4];
  logic ov [4];
  logic ol [4];
  logic bz [4];
  logic dn [4];
  logic [31:0] od [4];

  int n_total;
  int n_bad;
  logic [7:0] ma [8][8];
  logic [7:0] mb [8][8];
  longint mc [4][8][8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NG = (g == 2) ? 2 : ((g == 3) ? 8 : 4);
    localparam int unsigned SG = (g == 1) ? 1 : 0;
    localparam int unsigned AW = 16 + $clog2(NG);
    logic [AW-1:0] od_w;
    logic ir_w, ov_w, ol_w, bz_w, dn_w;
    systolic_mm_core #(.BITWIDTH(8), .N(NG), .ACCWIDTH(AW), .SIGNED(SG)) u_dut (
      .clk(clk), .reset(rst_n), .start(st[g]), .acc_clear(clr[g]),
      .in_valid(iv[g]), .in_ready(ir_w), .in_data(idata[g]),
      .out_valid(ov_w), .out_ready(ordy[g]), .out_data(od_w),
      .out_last(ol_w), .busy(bz_w), .done(dn_w)
    );
    assign od[g] = 32'(od_w);
    assign ir[g] = ir_w;
    assign ov[g] = ov_w;
    assign ol[g] = ol_w;
    assign bz[g] = bz_w;
    assign dn[g] = dn_w;
  end

  function automatic int nval(input int k);
    if (k == 2) return 2;
    if (k == 3) return 8;
    return 4;
  endfunction

  function automatic int accw(input int k);
    return 16 + $clog2(nval(k));
  endfunction

  function automatic longint ev(input int k, input logic [7:0] v);
    if (k == 1) return longint'($signed(v));
    return longint'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ma[i][j] = v;
        mb[i][j] = v;
      end
  endtask

  // One full job on instance k; entered and left #1 after a rising edge.
  task automatic run_job(input int k, input bit c, input bit gaps, input int bp_at,
                         input bit spam, input bit timing, input string name);
    int n, nn, cyc, in_idx, out_idx, first_ov, bp_left, budget;
    longint s, mask;
    longint expv[$];
    bit hs_in, hs_out;
    n = nval(k);
    nn = n * n;
    mask = (longint'(1) << accw(k)) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = c ? 0 : mc[k][i][j];
        for (int q = 0; q < n; q++) s += ev(k, ma[i][q]) * ev(k, mb[q][j]);
        s = s & mask;
        mc[k][i][j] = s;
        expv.push_back(s);
      end

    st[k] = 1'b1;
    clr[k] = c;
    @(posedge clk); #1;
    st[k] = 1'b0;
    clr[k] = 1'b0;
    cyc = 0; in_idx = 0; out_idx = 0; first_ov = -1; bp_left = 5;
    budget = 10 * nn + 3 * n + 100;
    while (out_idx < nn && cyc < budget) begin
      if (ov[k] && first_ov < 0) begin
        first_ov = cyc;
        check({name, " ready_in_drain"}, 64'(ir[k]), 64'(0));
      end
      iv[k] = (in_idx < 2 * nn) && (!gaps || $urandom_range(0, 2) != 0);
      if (!iv[k])            idata[k] = 8'($urandom);
      else if (in_idx < nn)  idata[k] = ma[in_idx / n][in_idx % n];
      else                   idata[k] = mb[(in_idx - nn) / n][(in_idx - nn) % n];
      if (bp_at >= 0 && ov[k] && out_idx == bp_at && bp_left > 0) begin
        ordy[k] = 1'b0;
        bp_left--;
        check($sformatf("%s hold%0d", name, bp_left), 64'(od[k]), 64'(expv[bp_at]));
      end else begin
        ordy[k] = 1'b1;
      end
      st[k] = spam && ($urandom_range(0, 1) == 1) &&
              ((in_idx >= nn && in_idx < 2 * nn) || ov[k]);
      clr[k] = st[k];
      hs_in = iv[k] && ir[k];
      hs_out = ov[k] && ordy[k];
      if (hs_out) begin
        check($sformatf("%s c%0d", name, out_idx), 64'(od[k]), 64'(expv[out_idx]));
        check($sformatf("%s last%0d", name, out_idx), 64'(ol[k]), 64'(out_idx == nn - 1));
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_in) in_idx++;
      if (hs_out) out_idx++;
    end
    st[k] = 1'b0; clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
    check({name, " outputs_seen"}, 64'(out_idx), 64'(nn));
    check({name, " done"}, 64'(dn[k]), 64'(1));
    check({name, " idle_busy"}, 64'(bz[k]), 64'(0));
    check({name, " idle_valid"}, 64'(ov[k]), 64'(0));
    if (timing) begin
      check({name, " first_valid_cyc"}, 64'(first_ov), 64'(2 * nn + 3 * n - 1));
      check({name, " job_cyc"}, 64'(cyc), 64'(3 * nn + 3 * n - 1));
    end
    @(posedge clk); #1;
    check({name, " done_pulse"}, 64'(dn[k]), 64'(0));
  endtask

  // Start a job, load everything, then hit reset a couple of cycles into compute.
  task automatic abort_job(input int k);
    int n, nn;
    n = nval(k);
    nn = n * n;
    st[k] = 1'b1; clr[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0; clr[k] = 1'b0; iv[k] = 1'b1;
    for (int idx = 0; idx < 2 * nn; idx++) begin
      idata[k] = (idx < nn) ? ma[idx / n][idx % n] : mb[(idx - nn) / n][(idx - nn) % n];
      @(posedge clk); #1;
    end
    iv[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort busy_before", 64'(bz[k]), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 64'(ir[k]), 64'(0));
    check("abort out_valid", 64'(ov[k]), 64'(0));
    check("abort out_data", 64'(od[k]), 64'(0));
    check("abort out_last", 64'(ol[k]), 64'(0));
    check("abort busy", 64'(bz[k]), 64'(0));
    check("abort done", 64'(dn[k]), 64'(0));
    @(posedge clk); #1;
    check("abort busy_held", 64'(bz[k]), 64'(0));
    check("abort valid_held", 64'(ov[k]), 64'(0));
    rst_n = 1'b1;
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) mc[q][i][j] = 0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st[k] = 1'b0; clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; idata[k] = '0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) mc[k][i][j] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d in_ready", k), 64'(ir[k]), 64'(0));
      check($sformatf("rst%0d out_valid", k), 64'(ov[k]), 64'(0));
      check($sformatf("rst%0d out_data", k), 64'(od[k]), 64'(0));
      check($sformatf("rst%0d busy", k), 64'(bz[k]), 64'(0));
    end
    check("rst out_last", 64'(ol[0]), 64'(0));
    check("rst done", 64'(dn[0]), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity times a counting matrix, then accumulate, then clear again with backpressure
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = 8'(4 * i + j);
      end
    run_job(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, "ident");
    run_job(0, 1'b0, 1'b0, -1, 1'b0, 1'b1, "accum");
    run_job(0, 1'b1, 1'b0, 2, 1'b0, 1'b0, "bp");

    // Extreme operand values
    fill_const(8'd255);
    run_job(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, "u255");
    fill_const(8'h80);
    run_job(1, 1'b1, 1'b0, -1, 1'b0, 1'b1, "s128");

    // Same random job with and without input gaps
    fill_rand();
    run_job(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, "rnd");
    run_job(0, 1'b1, 1'b1, -1, 1'b0, 1'b0, "gaps");

    // Reset mid-compute, then an accumulate job must see cleared accumulators
    fill_rand();
    abort_job(0);
    fill_rand();
    run_job(0, 1'b0, 1'b0, -1, 1'b0, 1'b1, "post_rst");

    // Stray start pulses while loading B and draining, across sizes
    fill_rand();
    run_job(2, 1'b1, 1'b0, -1, 1'b1, 1'b1, "spam2");
    fill_rand();
    run_job(0, 1'b1, 1'b0, -1, 1'b1, 1'b1, "spam4");
    fill_rand();
    run_job(3, 1'b1, 1'b0, -1, 1'b1, 1'b1, "spam8");
    fill_rand();
    run_job(3, 1'b0, 1'b1, 3, 1'b0, 1'b0, "acc8");

    // Signed random jobs with accumulation
    fill_rand();
    run_job(1, 1'b1, 1'b1, -1, 1'b0, 1'b0, "srnd");
    fill_rand();
    run_job(1, 1'b0, 1'b0, -1, 1'b1, 1'b1, "sacc");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
